tail_deframer: RTL and testbench

Receive-side counterpart of the pixel `framer`. It consumes the packed byte stream that the framer emits (data bytes followed by tail bytes) and unpacks each byte back into per-pixel elements. It checks that the two tail bytes arrive exactly after the expected payload and resynchronises on a bad tail. It sits in the loopback/verification path and in any downstream FPGA stage that consumes the CNN output stream.

---
 rtl/stream_pkg.sv | 20 ++
 rtl/tail_deframer_byte_unpacker.sv | 49 ++++
 rtl/tail_deframer.sv | 145 ++++++++++++++
 tb/tb_tail_deframer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared pixel-stream definitions: deframer FSM states, default tail bytes
// and the ceiling-division helper used to size packed payloads.
package stream_pkg;

  typedef enum logic [2:0] {
    ST_DATA,
    ST_TAIL0,
    ST_TAIL1,
    ST_RESYNC0,
    ST_RESYNC1
  } tail_state_e;

  localparam logic [7:0] TAIL_BYTE0 = 8'hA5;
  localparam logic [7:0] TAIL_BYTE1 = 8'h5A;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/tail_deframer_byte_unpacker.sv
// byte_unpacker: holds one packed byte and shifts its valid elements out
// LSB-first; the next byte may load while the current last element leaves.
module byte_unpacker #(
  parameter int unsigned UnpackedWidth = 1,
  parameter int unsigned PackedNum     = 8,
  parameter int unsigned CntW          = $clog2(PackedNum + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic [CntW-1:0]          in_count,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [UnpackedWidth-1:0] out_data,
  output logic                     out_last
);

  logic [7:0]      hold;
  logic [CntW-1:0] left;
  logic            hold_last;

  assign out_valid = (left != '0);
  assign out_data  = hold[UnpackedWidth-1:0];
  assign out_last  = hold_last && (left == CntW'(1));

  // Reload on the final element of a non-final byte so the stream has no bubble.
  assign in_ready = enable &&
                    ((left == '0) || ((left == CntW'(1)) && out_ready && !hold_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      left      <= '0;
      hold_last <= 1'b0;
    end else if (in_valid && in_ready) begin
      hold      <= in_data;
      left      <= in_count;
      hold_last <= in_last;
    end else if (out_valid && out_ready) begin
      hold <= hold >> UnpackedWidth;
      left <= left - CntW'(1);
    end
  end

endmodule

// File: rtl/tail_deframer.sv
// tail_deframer: unpacks framed byte stream into elements and checks the tail.
// Optional macro TAIL_DEFRAMER_STATS_EN adds saturating frame ok/err counters.
module tail_deframer
  import stream_pkg::*;
#(
  parameter int unsigned UnpackedWidth  = 1,
  parameter int unsigned PackedNum      = 8,
  parameter int unsigned PacketLenElems = 318 * 238,
  parameter logic [7:0]  TailByte0      = TAIL_BYTE0,
  parameter logic [7:0]  TailByte1      = TAIL_BYTE1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [7:0]               data_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [UnpackedWidth-1:0] unpacked_o,
  output logic                     last_o,
  output logic                     frame_ok_o,
  output logic                     frame_err_o
`ifdef TAIL_DEFRAMER_STATS_EN
  ,
  output logic [15:0]              frames_ok_o,
  output logic [15:0]              frames_err_o
`endif
);

  localparam int unsigned CntW        = $clog2(PacketLenElems + 1);
  localparam int unsigned ByteCntW    = $clog2(PackedNum + 1);
  localparam int unsigned PacketBytes = ceil_div(PacketLenElems, PackedNum);
  localparam int unsigned LastCount   = PacketLenElems - (PacketBytes - 1) * PackedNum;

  tail_state_e         state;
  logic [CntW-1:0]     elem_cnt;
  logic [CntW-1:0]     taken;
  logic [CntW-1:0]     remaining;
  logic                consume;
  logic                byte_last;
  logic [ByteCntW-1:0] byte_count;
  logic                unpack_ready;
  logic                in_data_state;

  assign in_data_state = (state == ST_DATA);
  assign consume       = valid_o && ready_i;
  assign ready_o       = in_data_state ? unpack_ready : 1'b1;

  // A new byte only loads when the held byte is empty or emptying this cycle,
  // so elements handed to the unpacker equal delivered plus the one leaving now.
  always_comb begin
    taken      = elem_cnt + CntW'(consume);
    remaining  = CntW'(PacketLenElems) - taken;
    byte_last  = (32'(remaining) <= PackedNum);
    byte_count = byte_last ? ByteCntW'(LastCount) : ByteCntW'(PackedNum);
  end

  byte_unpacker #(
    .UnpackedWidth(UnpackedWidth),
    .PackedNum    (PackedNum),
    .CntW         (ByteCntW)
  ) u_unpacker (
    .clk      (clk_i),
    .rst      (rst_i),
    .enable   (in_data_state),
    .in_valid (valid_i),
    .in_ready (unpack_ready),
    .in_data  (data_i),
    .in_count (byte_count),
    .in_last  (byte_last),
    .out_valid(valid_o),
    .out_ready(ready_i),
    .out_data (unpacked_o),
    .out_last (last_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_DATA;
      elem_cnt    <= '0;
      frame_ok_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_ok_o  <= 1'b0;
      frame_err_o <= 1'b0;
      unique case (state)
        ST_DATA: begin
          if (consume) begin
            elem_cnt <= elem_cnt + CntW'(1);
            if (last_o) state <= ST_TAIL0;
          end
        end
        ST_TAIL0: begin
          if (valid_i) begin
            if (data_i == TailByte0) begin
              state <= ST_TAIL1;
            end else begin
              frame_err_o <= 1'b1;
              state       <= ST_RESYNC0;
            end
          end
        end
        ST_TAIL1: begin
          if (valid_i) begin
            if (data_i == TailByte1) begin
              frame_ok_o <= 1'b1;
              elem_cnt   <= '0;
              state      <= ST_DATA;
            end else begin
              frame_err_o <= 1'b1;
              state       <= (data_i == TailByte0) ? ST_RESYNC1 : ST_RESYNC0;
            end
          end
        end
        ST_RESYNC0: begin
          if (valid_i && (data_i == TailByte0)) state <= ST_RESYNC1;
        end
        ST_RESYNC1: begin
          if (valid_i) begin
            if (data_i == TailByte1) begin
              elem_cnt <= '0;
              state    <= ST_DATA;
            end else if (data_i != TailByte0) begin
              state <= ST_RESYNC0;
            end
          end
        end
        default: state <= ST_DATA;
      endcase
    end
  end

`ifdef TAIL_DEFRAMER_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frames_ok_o  <= '0;
      frames_err_o <= '0;
    end else begin
      if (frame_ok_o && (frames_ok_o != '1))   frames_ok_o  <= frames_ok_o + 16'd1;
      if (frame_err_o && (frames_err_o != '1)) frames_err_o <= frames_err_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tail_deframer.sv
// Directed bench for tail_deframer: a 16-element and a 12-element instance
// share stimulus; a select signal routes bytes to one of them at a time.
module tb_tail_deframer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic       ready_in;
  logic       sel;

  logic v16_in, r16_o, v16_o, u16, l16, ok16, err16;
  logic v12_in, r12_o, v12_o, u12, l12, ok12, err12;
`ifdef TAIL_DEFRAMER_STATS_EN
  logic [15:0] fok16, ferr16, fok12, ferr12;
`endif

  assign v16_in = valid && !sel;
  assign v12_in = valid && sel;

  logic m_ready, m_valid, m_elem, m_last, m_ok, m_err;
  assign m_ready = sel ? r12_o : r16_o;
  assign m_valid = sel ? v12_o : v16_o;
  assign m_elem  = sel ? u12   : u16;
  assign m_last  = sel ? l12   : l16;
  assign m_ok    = sel ? ok12  : ok16;
  assign m_err   = sel ? err12 : err16;

  tail_deframer #(.UnpackedWidth(1), .PackedNum(8), .PacketLenElems(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(v16_in), .ready_o(r16_o), .data_i(data),
    .valid_o(v16_o), .ready_i(ready_in), .unpacked_o(u16), .last_o(l16),
    .frame_ok_o(ok16), .frame_err_o(err16)
`ifdef TAIL_DEFRAMER_STATS_EN
    , .frames_ok_o(fok16), .frames_err_o(ferr16)
`endif
  );

  tail_deframer #(.UnpackedWidth(1), .PackedNum(8), .PacketLenElems(12)) dut12 (
    .clk_i(clk), .rst_i(rst), .valid_i(v12_in), .ready_o(r12_o), .data_i(data),
    .valid_o(v12_o), .ready_i(ready_in), .unpacked_o(u12), .last_o(l12),
    .frame_ok_o(ok12), .frame_err_o(err12)
`ifdef TAIL_DEFRAMER_STATS_EN
    , .frames_ok_o(fok12), .frames_err_o(ferr12)
`endif
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [7:0] bq[$];
  logic       exp_e[$];
  logic       exp_l[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic push_elems(input logic [7:0] b, input int unsigned n, input bit last_byte);
    for (int unsigned i = 0; i < n; i++) begin
      exp_e.push_back(b[i]);
      exp_l.push_back(last_byte && (i == n - 1));
    end
  endtask

  // Good frame of 16 elements from two bytes plus tail.
  task automatic push_frame16(input logic [7:0] b0, input logic [7:0] b1);
    bq.push_back(b0); bq.push_back(b1); bq.push_back(8'hA5); bq.push_back(8'h5A);
    push_elems(b0, 8, 1'b0);
    push_elems(b1, 8, 1'b1);
  endtask

  task automatic run(input string tag, input bit bp, input int unsigned max_elems,
                     input int unsigned exp_ok, input int unsigned exp_err,
                     output int first_acc, output int first_el, output int last_el);
    int unsigned cyc = 0, idle = 0, delivered = 0, oks = 0, errs = 0;
    bit   stalled = 1'b0;
    logic pu = 1'b0, pl = 1'b0;
    first_acc = -1; first_el = -1; last_el = -1;
    forever begin
      @(negedge clk);
      valid    = (bq.size() != 0);
      data     = valid ? bq[0] : 8'h00;
      ready_in = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled) begin
        check({tag, "_hold_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_hold_elem"},  32'(m_elem),  32'(pu));
        check({tag, "_hold_last"},  32'(m_last),  32'(pl));
      end
      if (m_valid && ready_in) begin
        if (exp_e.size() == 0) begin
          check({tag, "_extra_elem"}, 32'(m_valid), 32'd0);
        end else begin
          check({tag, "_elem"}, 32'(m_elem), 32'(exp_e.pop_front()));
          check({tag, "_last"}, 32'(m_last), 32'(exp_l.pop_front()));
        end
        delivered++;
        if (first_el < 0) first_el = int'(cyc);
        last_el = int'(cyc);
      end
      if (m_ok)  oks++;
      if (m_err) errs++;
      if (valid && m_ready) begin
        if (first_acc < 0) first_acc = int'(cyc);
        void'(bq.pop_front());
      end
      stalled = m_valid && !ready_in;
      pu = m_elem;
      pl = m_last;
      cyc++;
      if (max_elems != 0 && delivered >= max_elems) break;
      if (bq.size() == 0 && exp_e.size() == 0) idle++; else idle = 0;
      if (idle >= 4) break;
      if (cyc >= 2000) begin
        total++;
        $error("FAIL %s_timeout observed=%0d pending expected=0 pending", tag, bq.size() + exp_e.size());
        break;
      end
    end
    if (max_elems == 0) begin
      check({tag, "_ok_pulses"},  oks,  exp_ok);
      check({tag, "_err_pulses"}, errs, exp_err);
    end
  endtask

  int fa, fe, le;

  initial begin
    rst = 1'b0; valid = 1'b0; data = 8'h00; ready_in = 1'b1; sel = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_ready16", 32'(r16_o), 32'd1);
    check("rst_valid16", 32'(v16_o), 32'd0);
    check("rst_last16",  32'(l16),   32'd0);
    check("rst_ok16",    32'(ok16),  32'd0);
    check("rst_err16",   32'(err16), 32'd0);
    check("rst_ready12", 32'(r12_o), 32'd1);
    check("rst_valid12", 32'(v12_o), 32'd0);
`ifdef TAIL_DEFRAMER_STATS_EN
    check("rst_fok16",  32'(fok16),  32'd0);
    check("rst_ferr16", 32'(ferr16), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Good frame: 0F,F0 -> 1111 0000 0000 1111
    push_frame16(8'h0F, 8'hF0);
    run("good16", 1'b0, 0, 1, 0, fa, fe, le);
    check("good16_latency", 32'(fe - fa), 32'd1);
    check("good16_span",    32'(le - fe), 32'd15);

    // Partial final byte on the 12-element instance; pad nibble of FA dropped
    sel = 1'b1;
    bq = '{8'h0F, 8'hFA, 8'hA5, 8'h5A};
    push_elems(8'h0F, 8, 1'b0);
    push_elems(8'hFA, 4, 1'b1);
    run("partial12", 1'b0, 0, 1, 0, fa, fe, le);
    check("partial12_span", 32'(le - fe), 32'd11);
    sel = 1'b0;

    // Bad tail, resync on A5 5A, then a good frame
    bq = '{8'h00, 8'h00, 8'hA5, 8'h00, 8'hA5, 8'h5A};
    push_elems(8'h00, 8, 1'b0);
    push_elems(8'h00, 8, 1'b1);
    push_frame16(8'h0F, 8'hF0);
    run("badtail", 1'b0, 0, 1, 1, fa, fe, le);

    // Random backpressure across three frames
    push_frame16(8'h0F, 8'hF0);
    push_frame16(8'h3C, 8'h81);
    push_frame16(8'hAA, 8'h55);
    run("backpressure", 1'b1, 0, 3, 0, fa, fe, le);

    // Reset after five delivered elements, then a full good frame
    bq = '{8'h0F, 8'hF0};
    push_elems(8'h0F, 5, 1'b0);
    run("rst_pre", 1'b0, 5, 0, 0, fa, fe, le);
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    #1;
    check("midrst_valid", 32'(v16_o), 32'd0);
    check("midrst_ready", 32'(r16_o), 32'd1);
    check("midrst_last",  32'(l16),   32'd0);
    check("midrst_ok",    32'(ok16),  32'd0);
    check("midrst_err",   32'(err16), 32'd0);
`ifdef TAIL_DEFRAMER_STATS_EN
    check("midrst_fok", 32'(fok16), 32'd0);
`endif
    bq.delete(); exp_e.delete(); exp_l.delete();
    @(negedge clk) rst = 1'b0;
    push_frame16(8'hC3, 8'h18);
    run("post_rst", 1'b0, 0, 1, 0, fa, fe, le);

    // One bad frame then one good frame since reset: totals 2 ok, 1 err
    bq = '{8'h00, 8'h00, 8'hA5, 8'h00, 8'hA5, 8'h5A};
    push_elems(8'h00, 8, 1'b0);
    push_elems(8'h00, 8, 1'b1);
    push_frame16(8'h69, 8'h96);
    run("stats_seq", 1'b0, 0, 1, 1, fa, fe, le);
`ifdef TAIL_DEFRAMER_STATS_EN
    check("stats_frames_ok",  32'(fok16),  32'd2);
    check("stats_frames_err", 32'(ferr16), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
